line_endpoint_latch: RTL
========================

// Module: line_endpoint_latch
// PURPOSE
//  Upstream feeder for the line sprite. Accepts line endpoints from tracking logic over valid/ready.
//  Orders endpoints so x1<=x2 and clamps them to the active area. Holds the result in a shadow register.
//  Commits it to the sprite inputs only at frame start (first blanking pixel), then pulses the sprite reset.
//  The sprite therefore always restarts from a stable, consistent endpoint set each frame.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line; frame start when hcount_in==H_ACTIVE
//  V_ACTIVE  720   active lines per frame; frame start when vcount_in==V_ACTIVE
// PORTS
//  clk_in       in   1   pixel clock; sole clock
//  rst_in       in   1   synchronous, active-high reset
//  hcount_in    in   11  current pixel column
//  vcount_in    in   10  current pixel row
//  valid_in     in   1   endpoint pair valid
//  ready_out    out  1   block can accept a pair this cycle
//  xa_in        in   11  endpoint A x (unsigned)
//  ya_in        in   10  endpoint A y (unsigned)
//  xb_in        in   11  endpoint B x
//  yb_in        in   10  endpoint B y
//  x1_out       out  11  committed left x (x1_out<=x2_out always)
//  y1_out       out  10  y paired with x1_out
//  x2_out       out  11  committed right x
//  y2_out       out  10  y paired with x2_out
//  line_rst_out out  1   one-cycle reset pulse to the sprite after each commit
//  steep_out    out  1   committed line has |dy|>dx (outside sprite's octant)
//  drop_cnt_out out  8   saturating count of pending pairs overwritten before commit
// BEHAVIOUR
//  Reset: all outputs 0, ready_out 0 during rst_in, state IDLE, pending=0, shadow=0.
//  FSM: IDLE -> SORT on accept (valid_in&&ready_out); SORT -> IDLE after 1 cycle.
//   ready_out=1 in IDLE, 0 in SORT. Inputs are captured into a stage register on accept.
//  SORT cycle: if xa>xb swap pairs (tie: keep A as point 1).
//   Clamp x to H_ACTIVE-1 and y to V_ACTIVE-1 after the swap; the re-ordered result still satisfies x1<=x2.
//   Write shadow and set pending=1.
//   If pending was already 1, increment drop_cnt_out, saturating at 255.
//  Commit: frame_start = (hcount_in==H_ACTIVE && vcount_in==V_ACTIVE), sampled each cycle.
//   When frame_start&&pending: outputs<=shadow at that edge, pending<=0, steep_out<=(|y2-y1|>x2-x1).
//   line_rst_out is high for exactly the following cycle. The sprite sees the new endpoints with its reset.
//   When frame_start&&!pending: outputs hold and no pulse.
//  Simultaneous SORT exit and frame_start: the commit uses the old shadow if pending.
//   The new pair becomes the pending value (pending stays 1, no drop counted).
//   If pending was 0, nothing commits this frame.
//  Arithmetic: dx, dy use 12-bit signed intermediates; |dy| is computed by a conditional negate; no truncation.
//  Outputs change only at commit; they are glitch-free registered values.
//  rst_in mid-SORT or with pending: everything clears; line_rst_out is 0 in the cycle after reset.
// CONFIGURATION
//  LINE_SMOOTH_EN defined: at SORT, if a shadow has been written since reset, each clamped coordinate becomes
//   shadow=(shadow+new)>>1 (12-bit sum, floor). The first pair after reset loads directly.
//   Averaging is per field after ordering. drop_cnt still counts overwrites.
//  LINE_SMOOTH_EN undefined: shadow is replaced by the new ordered, clamped pair.
// TESTING
//  1 Reset, then A=(100,50) B=(300,80), wait frame start -> x1/y1=100/50, x2/y2=300/80, one line_rst_out pulse, steep_out=0.
//  2 A=(500,400) B=(200,100) -> swapped: x1=200,y1=100,x2=500,y2=400; steep_out=0.
//  3 A=(10,10) B=(20,300) -> steep_out=1. A=(2000,900) B=(0,0) -> x1=0,y1=0,x2=1279,y2=719.
//  4 Three pairs accepted within one frame -> last pair committed, drop_cnt_out=2; ready_out low exactly one cycle per accept.
//  5 Accept timed so SORT exits on the frame_start cycle with old pending P -> P commits; new pair commits next frame.
//  6 rst_in during SORT with pending -> no commit or pulse at the next frame start; outputs remain 0.
//  7 (LINE_SMOOTH_EN) pairs (100,50)-(300,80) then (200,150)-(400,180) in one frame -> commit x1=150,y1=100,x2=350,y2=130.

Source files
------------

// File: rtl/line_endpoint_latch.sv
// Line endpoint shadow latch: orders and clamps endpoint pairs, commits at frame start.
// Optional LINE_SMOOTH_EN averages each new pair into the shadow register.
`timescale 1ns/1ps
module line_endpoint_latch #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [10:0] xa_in,
    input  logic [9:0]  ya_in,
    input  logic [10:0] xb_in,
    input  logic [9:0]  yb_in,
    output logic [10:0] x1_out,
    output logic [9:0]  y1_out,
    output logic [10:0] x2_out,
    output logic [9:0]  y2_out,
    output logic        line_rst_out,
    output logic        steep_out,
    output logic [7:0]  drop_cnt_out
);

    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - 1);

    typedef enum logic {IDLE, SORT} state_t;

    state_t      state;
    logic        pending;
    logic [10:0] st_xa, st_xb;
    logic [9:0]  st_ya, st_yb;
    logic [10:0] sh_x1, sh_x2;
    logic [9:0]  sh_y1, sh_y2;

    logic        swap, frame_start, commit, steep_c;
    logic [10:0] cx1, cx2, nx1, nx2;
    logic [9:0]  cy1, cy2, ny1, ny2;
    logic signed [11:0] dx, dy, ady;

    assign ready_out   = (state == IDLE) && !rst_in;
    assign frame_start = (hcount_in == 11'(H_ACTIVE)) &&
                         (vcount_in == 10'(V_ACTIVE));
    assign commit      = frame_start && pending;

    // Clamping after the swap is monotonic, so x1<=x2 survives it.
    always_comb begin
        swap = st_xa > st_xb;
        cx1  = swap ? st_xb : st_xa;
        cy1  = swap ? st_yb : st_ya;
        cx2  = swap ? st_xa : st_xb;
        cy2  = swap ? st_ya : st_yb;
        if (cx1 > X_MAX) cx1 = X_MAX;
        if (cx2 > X_MAX) cx2 = X_MAX;
        if (cy1 > Y_MAX) cy1 = Y_MAX;
        if (cy2 > Y_MAX) cy2 = Y_MAX;
    end

`ifdef LINE_SMOOTH_EN
    logic has_shadow;

    function automatic logic [10:0] avg_x(input logic [10:0] a,
                                          input logic [10:0] b);
        logic [11:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[11:1];
    endfunction

    function automatic logic [9:0] avg_y(input logic [9:0] a,
                                         input logic [9:0] b);
        logic [11:0] s;
        s = {2'b0, a} + {2'b0, b};
        return s[10:1];
    endfunction

    always_comb begin
        nx1 = has_shadow ? avg_x(sh_x1, cx1) : cx1;
        nx2 = has_shadow ? avg_x(sh_x2, cx2) : cx2;
        ny1 = has_shadow ? avg_y(sh_y1, cy1) : cy1;
        ny2 = has_shadow ? avg_y(sh_y2, cy2) : cy2;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            has_shadow <= 1'b0;
        else if (state == SORT)
            has_shadow <= 1'b1;
    end
`else
    always_comb begin
        nx1 = cx1;
        nx2 = cx2;
        ny1 = cy1;
        ny2 = cy2;
    end
`endif

    always_comb begin
        dx      = $signed({1'b0, sh_x2}) - $signed({1'b0, sh_x1});
        dy      = $signed({2'b0, sh_y2}) - $signed({2'b0, sh_y1});
        ady     = (dy < 0) ? -dy : dy;
        steep_c = ady > dx;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            pending      <= 1'b0;
            st_xa        <= '0;
            st_ya        <= '0;
            st_xb        <= '0;
            st_yb        <= '0;
            sh_x1        <= '0;
            sh_y1        <= '0;
            sh_x2        <= '0;
            sh_y2        <= '0;
            x1_out       <= '0;
            y1_out       <= '0;
            x2_out       <= '0;
            y2_out       <= '0;
            line_rst_out <= 1'b0;
            steep_out    <= 1'b0;
            drop_cnt_out <= '0;
        end else begin
            line_rst_out <= commit;
            if (commit) begin
                x1_out    <= sh_x1;
                y1_out    <= sh_y1;
                x2_out    <= sh_x2;
                y2_out    <= sh_y2;
                steep_out <= steep_c;
                pending   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        st_xa <= xa_in;
                        st_ya <= ya_in;
                        st_xb <= xb_in;
                        st_yb <= yb_in;
                        state <= SORT;
                    end
                end
                SORT: begin
                    sh_x1   <= nx1;
                    sh_y1   <= ny1;
                    sh_x2   <= nx2;
                    sh_y2   <= ny2;
                    pending <= 1'b1;
                    // A pair that commits this edge was not overwritten.
                    if (pending && !commit && drop_cnt_out != 8'hFF)
                        drop_cnt_out <= drop_cnt_out + 8'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
